// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with optional two-entry skid buffer.
// SKID=1: registered in_ready, main register M plus skid register S.
// SKID=0: single register M, in_ready derived combinationally from out_ready.
// Ports:
//   clk, reset (async, active-high)
//   flush                      - synchronous kill of held entries
//   in_valid/in_ready/in_data  - upstream handshake and payload
//   out_valid/out_ready/out_data - downstream handshake and head entry
//   count                      - number of held entries (0..2)
module pipe_skid_reg #(
  parameter int unsigned DATA_W = 71,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Low CTRL_W bits set; these are the control bits cleared on flush.
  localparam logic [DATA_W-1:0] CTRL_MASK = ~({DATA_W{1'b1}} << CTRL_W);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [DATA_W-1:0] s_q;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != EMPTY);
  assign count     = 2'(state_q);
  assign out_data  = m_q;
  assign out_fire  = out_valid & out_ready;
  assign in_fire   = in_valid & in_ready & ~flush;

  // Next state and main register
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          m_d     = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_ready) begin
          m_d = in_data;
        end else if (in_fire) begin
          if (SKID != 0) state_d = FULL;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          m_d     = s_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush overrides any transfer: M keeps its data bits, control bits drop.
    if (flush) begin
      state_d = EMPTY;
      m_d     = m_q & ~CTRL_MASK;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
    end
  end

  if (SKID != 0) begin : g_skid
    logic [DATA_W-1:0] s_d;
    logic              in_ready_q;

    // Skid register captures the input when the head is stalled.
    always_comb begin
      s_d = s_q;
      if (flush) begin
        s_d = s_q & ~CTRL_MASK;
      end else if ((state_q == ONE) && in_fire && !out_ready) begin
        s_d = in_data;
      end
    end

    // in_ready registered from next state: no path from out_ready.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s_q        <= '0;
        in_ready_q <= 1'b0;
      end else begin
        s_q        <= s_d;
        in_ready_q <= (state_d != FULL);
      end
    end

    assign in_ready = in_ready_q;
  end else begin : g_noskid
    assign s_q      = '0;
    assign in_ready = ~out_valid | out_ready;
  end

endmodule
